// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: byte-level I2C target. Oversamples and deglitches SCL/SDA,
// detects START/Sr/STOP, matches a 7-bit address, receives write bytes and
// transmits read bytes from a one-entry holding register, stretching SCL
// when read data is not yet available.
module i2c_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter bit          STRETCH_EN  = 1'b1
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  inout  logic       I_I2CSCL,
  inout  logic       I_I2CSDA,
  input  logic       I_SLV_EN,
  input  logic [6:0] I_SLV_ADR,
  input  logic [7:0] I_TXD,
  input  logic       I_TX_VALID,
  output logic       O_TX_READY,
  output logic [7:0] O_RXD,
  output logic       O_RX_VALID,
  output logic       O_ADDR_HIT,
  output logic       O_RW,
  output logic       O_START,
  output logic       O_STOP,
  output logic       O_NACK,
  output logic       O_BUSY
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_RX_BYTE  = 3'd3;
  localparam logic [2:0] ST_RX_ACK   = 3'd4;
  localparam logic [2:0] ST_LOAD     = 3'd5;
  localparam logic [2:0] ST_TX_BYTE  = 3'd6;
  localparam logic [2:0] ST_TX_ACK   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_f, sda_f, scl_fd, sda_fd;
  logic [CW-1:0]          scl_cnt, sda_cnt;
  logic                   scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]             state;
  logic [7:0]             shreg, hold;
  logic [3:0]             bitcnt;
  logic                   sda_low, scl_low, hold_full, rdy_en, hold_take;

  // Filter step: a line only changes after FILT_LEN consecutive differing samples
  function automatic logic [CW:0] filt_next(input logic raw, input logic cur,
                                            input logic [CW-1:0] cnt);
    if (raw == cur)                     return {cur, CW'(0)};
    else if (cnt == CW'(FILT_LEN - 1))  return {raw, CW'(0)};
    else                                return {cur, cnt + CW'(1)};
  endfunction

  assign I_I2CSCL = scl_low ? 1'b0 : 1'bz;
  assign I_I2CSDA = sda_low ? 1'b0 : 1'bz;

  assign scl_rise = scl_f & ~scl_fd;
  assign scl_fall = ~scl_f & scl_fd;
  // SCL must be high on both samples so a simultaneous SCL/SDA edge is not a condition
  assign start_c  = scl_f & scl_fd & sda_fd & ~sda_f;
  assign stop_c   = scl_f & scl_fd & ~sda_fd & sda_f;

  assign O_TX_READY = rdy_en & ~hold_full;
  assign hold_take  = (state == ST_LOAD) && hold_full && !start_c && !stop_c && I_SLV_EN;

  // Input synchronizers, glitch filters and edge history
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_fd   <= 1'b1;
      sda_fd   <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], I_I2CSCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], I_I2CSDA};
      {scl_f, scl_cnt} <= filt_next(scl_sync[SYNC_STAGES-1], scl_f, scl_cnt);
      {sda_f, sda_cnt} <= filt_next(sda_sync[SYNC_STAGES-1], sda_f, sda_cnt);
      scl_fd   <= scl_f;
      sda_fd   <= sda_f;
    end
  end

  // One-entry TX holding register; contents survive STOP
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      hold      <= '0;
      hold_full <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (I_TX_VALID && O_TX_READY) begin
        hold      <= I_TXD;
        hold_full <= 1'b1;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Protocol FSM: bus conditions first, then enable, then bit-level events
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      sda_low    <= 1'b0;
      scl_low    <= 1'b0;
      O_RXD      <= '0;
      O_RW       <= 1'b0;
      O_RX_VALID <= 1'b0;
      O_ADDR_HIT <= 1'b0;
      O_START    <= 1'b0;
      O_STOP     <= 1'b0;
      O_NACK     <= 1'b0;
      O_BUSY     <= 1'b0;
    end else begin
      O_RX_VALID <= 1'b0;
      O_ADDR_HIT <= 1'b0;
      O_START    <= 1'b0;
      O_STOP     <= 1'b0;
      O_NACK     <= 1'b0;
      if (start_c) begin
        O_START <= 1'b1;
        O_BUSY  <= 1'b1;
        bitcnt  <= '0;
        state   <= ST_ADDR;
        sda_low <= 1'b0;
        scl_low <= 1'b0;
      end else if (stop_c) begin
        O_STOP  <= 1'b1;
        O_BUSY  <= 1'b0;
        state   <= ST_IDLE;
        sda_low <= 1'b0;
        scl_low <= 1'b0;
      end else if (!I_SLV_EN) begin
        state   <= ST_IDLE;
        sda_low <= 1'b0;
        scl_low <= 1'b0;
      end else begin
        scl_low <= 1'b0;
        case (state)
          ST_IDLE: sda_low <= 1'b0;
          ST_ADDR, ST_RX_BYTE: begin
            if (scl_rise) begin
              shreg  <= {shreg[6:0], sda_f};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              if (state == ST_RX_BYTE) begin
                O_RXD      <= shreg;
                O_RX_VALID <= 1'b1;
                sda_low    <= 1'b1;
                state      <= ST_RX_ACK;
              end else if (shreg[7:1] == I_SLV_ADR) begin
                sda_low    <= 1'b1;
                O_RW       <= shreg[0];
                O_ADDR_HIT <= 1'b1;
                state      <= ST_ADDR_ACK;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (!O_RW) begin
                sda_low <= 1'b0;
                state   <= ST_RX_BYTE;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            bitcnt <= '0;
            if (hold_full) begin
              // Keep any stretch one more cycle so bit7 is on SDA before SCL is freed
              shreg   <= hold;
              sda_low <= ~hold[7];
              scl_low <= scl_low;
              state   <= ST_TX_BYTE;
            end else if (STRETCH_EN) begin
              scl_low <= 1'b1;
            end else begin
              shreg   <= 8'hFF;
              sda_low <= 1'b0;
              state   <= ST_TX_BYTE;
            end
          end
          ST_TX_BYTE: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_low <= 1'b0;
                state   <= ST_TX_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b1};
                sda_low <= ~shreg[6];
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise && sda_f) begin
              O_NACK <= 1'b1;
              state  <= ST_IDLE;
            end else if (scl_fall) begin
              state <= ST_LOAD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// Directed bench for i2c_slave: bit-banged bus master, pulse monitors and
// RX/TX scoreboards.
module tb_i2c_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       slv_en = 1'b1;
  logic [6:0] slv_adr = 7'h52;
  logic [7:0] txd = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, addr_hit, rw, o_start, o_stop, nack, busy;
  logic [7:0] rxd;

  wire  scl, sda;
  logic m_scl_low = 1'b0, m_sda_low = 1'b0, g_scl_low = 1'b0, g_sda_low = 1'b0;
  assign scl = (m_scl_low | g_scl_low) ? 1'b0 : 1'bz;
  assign sda = (m_sda_low | g_sda_low) ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  i2c_slave #(.SYNC_STAGES(2), .FILT_LEN(3), .STRETCH_EN(1'b1)) dut (
    .I_CLK(clk), .I_RST(rst), .I_I2CSCL(scl), .I_I2CSDA(sda),
    .I_SLV_EN(slv_en), .I_SLV_ADR(slv_adr), .I_TXD(txd), .I_TX_VALID(tx_valid),
    .O_TX_READY(tx_ready), .O_RXD(rxd), .O_RX_VALID(rx_valid), .O_ADDR_HIT(addr_hit),
    .O_RW(rw), .O_START(o_start), .O_STOP(o_stop), .O_NACK(nack), .O_BUSY(busy)
  );

  int errors = 0, checks = 0;
  int n_start = 0, n_stop = 0, n_hit = 0, n_rx = 0, n_nack = 0;
  logic slv_sda_seen = 1'b0, stretch_seen = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output pulses and RX scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (o_start)  n_start++;
      if (o_stop)   n_stop++;
      if (addr_hit) n_hit++;
      if (nack)     n_nack++;
      if (rx_valid) begin
        n_rx++;
        check("rx_expected", 32'(rxq.size() != 0), 32'd1);
        if (rxq.size() != 0) check("rxd", 32'(rxd), 32'(rxq.pop_front()));
      end
    end
  end

  // Bus lines pulled low while the master releases them mean the target drives them
  always @(posedge clk) begin
    if (sda === 1'b0 && !m_sda_low && !g_sda_low) slv_sda_seen <= 1'b1;
    if (scl === 1'b0 && !m_scl_low && !g_scl_low) stretch_seen <= 1'b1;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int t = 0;
    m_scl_low = 1'b0;
    while (scl !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (scl !== 1'b1) check("scl_release_timeout", 32'(scl), 32'd1);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    m_sda_low = ~b;
    wq(Q);
    scl_release();
    wq(Q);
    r = sda;
    wq(Q);
    m_scl_low = 1'b1;
    wq(Q);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0;
    wq(Q);
    scl_release();
    wq(Q);
    m_sda_low = 1'b1;
    wq(Q);
    m_scl_low = 1'b1;
    wq(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wq(Q);
    scl_release();
    wq(Q);
    m_sda_low = 1'b0;
    wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(~mack, r);
  endtask

  task automatic load_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    txd      = b;
    tx_valid = 1'b1;
    txq.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  logic       ack;
  logic [7:0] d;
  int         st0, sp0, h0, r0, k0;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_outputs", 32'({tx_ready, rxd, rx_valid, addr_hit, rw, o_start, o_stop, nack, busy}), 32'd0);
    check("rst_lines", 32'({scl, sda}), 32'd3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    wq(4);

    // 1: write transfer
    h0 = n_hit; r0 = n_rx; sp0 = n_stop;
    bus_start();
    check("t1_busy", 32'(busy), 32'd1);
    write_byte(8'hA4, ack);
    check("t1_addr_ack", 32'(ack), 32'd1);
    rxq.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check("t1_data_ack", 32'(ack), 32'd1);
    bus_stop();
    check("t1_hits", 32'(n_hit - h0), 32'd1);
    check("t1_rw", 32'(rw), 32'd0);
    check("t1_rx_count", 32'(n_rx - r0), 32'd1);
    check("t1_rxd", 32'(rxd), 32'h3C);
    check("t1_stops", 32'(n_stop - sp0), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: address mismatch
    h0 = n_hit; r0 = n_rx;
    slv_sda_seen = 1'b0;
    bus_start();
    write_byte(8'hA6, ack);
    check("t2_addr_nack", 32'(ack), 32'd0);
    check("t2_busy_mid", 32'(busy), 32'd1);
    write_byte(8'h11, ack);
    check("t2_data_nack", 32'(ack), 32'd0);
    check("t2_busy_late", 32'(busy), 32'd1);
    bus_stop();
    check("t2_sda_driven", 32'(slv_sda_seen), 32'd0);
    check("t2_hits", 32'(n_hit - h0), 32'd0);
    check("t2_rx_count", 32'(n_rx - r0), 32'd0);
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3: read transfer with late second byte
    k0 = n_nack; sp0 = n_stop;
    load_tx(8'h96);
    stretch_seen = 1'b0;
    bus_start();
    write_byte(8'hA5, ack);
    check("t3_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    check("t3_byte0", 32'(d), 32'(txq.pop_front()));
    fork
      read_byte(1'b0, d);
      begin
        int t;
        repeat (50 * 4 * Q) @(negedge clk);
        check("t3_scl_stretched", 32'({scl, m_scl_low}), 32'd0);
        load_tx(8'h5A);
        t = 0;
        while (scl !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        check("t3_bit7_at_release", 32'({scl, sda}), 32'b10);
      end
    join
    check("t3_byte1", 32'(d), 32'(txq.pop_front()));
    check("t3_stretch_seen", 32'(stretch_seen), 32'd1);
    check("t3_nack", 32'(n_nack - k0), 32'd1);
    check("t3_rw", 32'(rw), 32'd1);
    bus_stop();
    check("t3_stops", 32'(n_stop - sp0), 32'd1);
    check("t3_busy_end", 32'(busy), 32'd0);

    // 4: repeated START
    st0 = n_start; sp0 = n_stop; h0 = n_hit;
    bus_start();
    write_byte(8'hA4, ack);
    rxq.push_back(8'h01);
    write_byte(8'h01, ack);
    check("t4_data_ack", 32'(ack), 32'd1);
    load_tx(8'h77);
    bus_start();
    write_byte(8'hA5, ack);
    check("t4_addr_ack", 32'(ack), 32'd1);
    check("t4_starts", 32'(n_start - st0), 32'd2);
    check("t4_hits", 32'(n_hit - h0), 32'd2);
    check("t4_rw", 32'(rw), 32'd1);
    check("t4_no_stop", 32'(n_stop - sp0), 32'd0);
    read_byte(1'b0, d);
    check("t4_read", 32'(d), 32'(txq.pop_front()));
    bus_stop();

    // 5: glitch rejection
    st0 = n_start; sp0 = n_stop; r0 = n_rx;
    bus_start();
    write_byte(8'hA4, ack);
    rxq.push_back(8'hC3);
    fork
      write_byte(8'hC3, ack);
      begin
        wq(15);
        g_sda_low = 1'b1;
        @(negedge clk);
        g_sda_low = 1'b0;
        wq(39);
        g_scl_low = 1'b1;
        @(negedge clk);
        g_scl_low = 1'b0;
      end
    join
    check("t5_ack", 32'(ack), 32'd1);
    check("t5_starts", 32'(n_start - st0), 32'd1);
    check("t5_no_stop", 32'(n_stop - sp0), 32'd0);
    check("t5_rx_count", 32'(n_rx - r0), 32'd1);
    check("t5_rxd", 32'(rxd), 32'hC3);
    bus_stop();

    // 6: reset mid-read while the target drives SDA low
    load_tx(8'h12);
    bus_start();
    write_byte(8'hA5, ack);
    check("t6_addr_ack", 32'(ack), 32'd1);
    wq(2);
    check("t6_sda_driven", 32'(sda), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_outputs", 32'({tx_ready, rxd, rx_valid, addr_hit, rw, o_start, o_stop, nack, busy}), 32'd0);
    check("t6_sda_released", 32'(sda), 32'd1);
    m_scl_low = 1'b0;
    wq(2);
    check("t6_scl_released", 32'(scl), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_tx_ready", 32'(tx_ready), 32'd1);
    txq.delete(0);

    check("rxq_drained", 32'(rxq.size()), 32'd0);
    check("txq_drained", 32'(txq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Byte-level I2C target (responder) for the same bus the team's i2c_master drives. It oversamples SCL/SDA on I_CLK, filters glitches, and detects START, repeated START and STOP. It matches a programmable 7-bit address, receives write bytes to a parallel output and transmits read bytes from a one-deep holding register. When the holding register is empty at the start of a read byte, it stretches SCL.

Parameters:
SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs
FILT_LEN, 3, consecutive identical samples needed before a filtered line changes
STRETCH_EN, 1, 1 = stretch SCL when TX data is missing; 0 = send 0xFF instead

Ports:
I_CLK  in  1  system clock, must be at least 20x SCL frequency
I_RST  in  1  synchronous reset, active-high
I_I2CSCL  inout  1  open-drain SCL; driven only 0 or Z
I_I2CSDA  inout  1  open-drain SDA; driven only 0 or Z
I_SLV_EN  in  1  target enable
I_SLV_ADR  in  7  own address
I_TXD  in  8  read-data byte
I_TX_VALID  in  1  I_TXD valid
O_TX_READY  out  1  holding register empty
O_RXD  out  8  last received write byte
O_RX_VALID  out  1  1-cycle pulse: O_RXD updated
O_ADDR_HIT  out  1  1-cycle pulse: address matched and ACKed
O_RW  out  1  R/W bit of last matched address (1 = read)
O_START  out  1  1-cycle pulse on START or repeated START
O_STOP  out  1  1-cycle pulse on STOP
O_NACK  out  1  1-cycle pulse: master NACKed a read byte
O_BUSY  out  1  bus busy, from START until STOP

Behaviour:
- Input path: SYNC_STAGES flops, then the FILT_LEN filter. Filtered edges give scl_rise and scl_fall. All protocol actions use filtered signals only.
- START is filtered SDA falling while filtered SCL is high. STOP is filtered SDA rising while filtered SCL is high. Both are detected from every state and take priority over bit events in the same cycle.
- On START: pulse O_START, set O_BUSY = 1, clear the bit counter, go to ADDR, release SDA and SCL.
- On STOP: pulse O_STOP, set O_BUSY = 0, go to IDLE, release both lines. Any partial byte is discarded.
- IDLE: no driving. Wait for START.
- ADDR: shift SDA into an 8-bit register MSB-first on each scl_rise. On the scl_fall after the 8th rise:
  - If I_SLV_EN = 1 and bits[7:1] equal I_SLV_ADR: drive SDA = 0, latch O_RW = bit0, pulse O_ADDR_HIT, go to ADDR_ACK.
  - Otherwise go to IDLE, where O_BUSY stays 1.
- ADDR_ACK and RX_ACK exit on the next scl_fall:
  - If O_RW = 0: release SDA and go to RX_BYTE.
  - If O_RW = 1: go to LOAD.
- RX_BYTE: shift on scl_rise. On the scl_fall after the 8th rise, in the same cycle: O_RXD gets the shift value, O_RX_VALID pulses, SDA is driven 0 (ACK), and the state goes to RX_ACK.
- RX has no back-pressure. The consumer must capture O_RXD on the O_RX_VALID pulse.
- LOAD, if the holding register is full: move it to the shifter, drive SDA from bit7 (0 = drive low, 1 = Z), go to TX_BYTE.
- LOAD, if the holding register is empty and STRETCH_EN = 1: drive SCL = 0 until a load arrives. Put bit7 on SDA, then release SCL one I_CLK cycle later.
- LOAD, if the holding register is empty and STRETCH_EN = 0: shift out 0xFF.
- TX_BYTE: on each scl_fall present the next bit. On the scl_fall that ends bit 0, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on scl_rise.
  - SDA = 0 (ACK): go to LOAD on the next scl_fall.
  - SDA = 1 (NACK): pulse O_NACK and go to IDLE.
- Holding register: one entry.
  - O_TX_READY = 1 when empty. A load happens when I_TX_VALID and O_TX_READY are both 1 in a cycle.
  - It empties on transfer to the shifter; O_TX_READY rises the next cycle.
  - Its contents persist across STOP.
- SDA changes are applied on filtered scl_fall. The filter latency provides the SDA hold time.
- If I_SLV_EN falls during a transfer: go to IDLE and release both lines within 1 cycle. O_BUSY continues to track the bus.
- Reset behaviour:
  - While I_RST is high: all outputs are 0 (O_RXD = 0x00, O_RW = 0), both lines are Z, the holding register is empty, the state is IDLE and the filters are preset to 1.
  - O_TX_READY = 1 from the first cycle after I_RST falls.
  - Reset mid-transfer releases both lines in the cycle I_RST is sampled high.

Test Plan:
1. Write transfer. I_SLV_ADR = 0x52; master sends START, 0xA4, 0x3C, STOP. Required: SDA low in both 9th clocks, one O_ADDR_HIT with O_RW = 0, O_RXD = 0x3C with exactly one O_RX_VALID, then O_STOP and O_BUSY = 0.
2. Address mismatch. Master sends START, 0xA6, 0x11, STOP. Required: SDA never driven, no O_ADDR_HIT or O_RX_VALID, O_BUSY high from START to STOP.
3. Read transfer. 0x96 preloaded; master sends START, 0xA5 and reads two bytes, ACK then NACK; 0x5A is offered 50 SCL periods late. Required:
   - SDA carries 0x96 then 0x5A.
   - SCL is held low until the 0x5A load, then released.
   - One O_NACK pulse, then IDLE.
4. Repeated START. Master writes 0x01, then sends Sr and 0xA5. Required: O_START pulses twice, O_RW = 1 after the second O_ADDR_HIT, no O_STOP between.
5. Glitch rejection. Inject a 1-cycle low on SCL and on SDA during a 0xC3 write. Required: O_RXD = 0xC3, no spurious START/STOP, exactly one O_RX_VALID.
6. Reset mid-read. Assert I_RST while the block drives SDA low. Required: both lines Z and all outputs 0 in the sampled cycle; O_TX_READY = 1 in the first cycle after release.
